trng_uart_tx: RTL and testbench
===============================

TRNG_UART_TX -- requirements
Module: trng_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, meaning clock cycles per UART bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter NUM_BYTES, default 4, meaning bytes sent per trigger; legal range 1..4.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port transmit  input  1  debounced button level, already synchronous to clk.
REQ-006 SHALL have port rnd_valid  input  1  high when rnd_data holds a fresh entropy word.
REQ-007 SHALL have port rnd_data  input  32  entropy word from the TRNG core.
REQ-008 SHALL have port rnd_ack  output  1  one-cycle pulse when rnd_data is captured.
REQ-009 SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy  output  1  high from capture until the final stop bit completes.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the last byte's stop bit ends.

Function
REQ-012 SHALL register transmit into transmit_d; a trigger is transmit=1 and transmit_d=0.
REQ-013 SHALL have FSM states IDLE, WAIT_RND, START, DATA, STOP.
REQ-014 IDLE on trigger: if rnd_valid=1, capture rnd_data, pulse rnd_ack, go to START; else go to WAIT_RND.
REQ-015 WAIT_RND: first cycle with rnd_valid=1 captures, pulses rnd_ack, goes to START; no timeout.
REQ-016 tx SHALL be registered; tx goes low in the cycle after capture (1-cycle latency).
REQ-017 START drives tx=0 for exactly CLKS_PER_BIT cycles, then goes to DATA.
REQ-018 DATA sends 8 bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit bit index wraps 7->0 on the exit to STOP.
REQ-019 STOP drives tx=1 for CLKS_PER_BIT cycles. If the byte index equals NUM_BYTES-1, go to IDLE; else increment the byte index and go to START.
REQ-020 Byte order SHALL be rnd_data[7:0] first, then [15:8], and so on; the captured word is held stable for the whole frame.
REQ-021 Each byte SHALL occupy exactly 10*CLKS_PER_BIT cycles; frames are back-to-back with no idle gap.
REQ-022 done SHALL pulse, and busy SHALL fall, in the cycle the FSM re-enters IDLE.
REQ-023 busy SHALL be high in WAIT_RND, START, DATA and STOP.
REQ-024 Triggers while busy=1 SHALL be ignored and not queued; a new frame needs a fresh rising edge after IDLE.
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1 and be cleared on every state transition.
REQ-026 The baud counter width SHALL be $clog2(CLKS_PER_BIT).

Reset
REQ-027 While rst_n=0: state=IDLE, tx=1, busy=0, done=0, rnd_ack=0, counters=0, captured word=0.
REQ-028 transmit_d SHALL reset to 1, so a button held through reset does not trigger.
REQ-029 Reset asserted mid-frame SHALL abort at once to the idle-high line; no partial byte completes.

Structure
REQ-030 Shared package trng_pkg SHALL hold the FSM state encoding localparams and default CLKS_PER_BIT.
REQ-031 One sub-module, uart_bit_timer, SHALL hold the baud counter and emit bit_end when count=CLKS_PER_BIT-1.

Verification
All scenarios use CLKS_PER_BIT=4, NUM_BYTES=2.
REQ-032 rnd_valid=1, rnd_data=0x0000A55A, transmit rises -> rnd_ack 1 cycle; tx frames 0,0x5A LSB-first,1 then 0,0xA5,1; 80 cycles total; done at end.
REQ-033 rnd_valid=0 at trigger, raised 20 cycles later -> busy high throughout, tx stays 1 until capture, frame starts the cycle after rnd_ack.
REQ-034 Second transmit edge mid-frame -> ignored; exactly one done pulse; tx returns idle.
REQ-035 transmit held 1 across rst_n release -> no frame; release then press -> one frame.
REQ-036 rst_n asserted at cycle 30 of a frame -> tx=1, busy=0 immediately; the next trigger sends a complete fresh frame.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG UART transmitter: FSM state encoding and
// the default bit period.
package trng_pkg;

    // 100 MHz system clock / 9600 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 10417;

    localparam logic [2:0] IDLE_ENC     = 3'd0;
    localparam logic [2:0] WAIT_RND_ENC = 3'd1;
    localparam logic [2:0] START_ENC    = 3'd2;
    localparam logic [2:0] DATA_ENC     = 3'd3;
    localparam logic [2:0] STOP_ENC     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = IDLE_ENC,
        WAIT_RND = WAIT_RND_ENC,
        START    = START_ENC,
        DATA     = DATA_ENC,
        STOP     = STOP_ENC
    } state_t;

endpackage

// File: rtl/trng_uart_tx_if.sv
// Entropy handshake plus serial/status outputs of the TRNG UART transmitter.
interface trng_uart_tx_if;

    logic        transmit;
    logic        rnd_valid;
    logic [31:0] rnd_data;
    logic        rnd_ack;
    logic        tx;
    logic        busy;
    logic        done;

    // Driver side: button and TRNG core
    modport master (
        output transmit, rnd_valid, rnd_data,
        input  rnd_ack, tx, busy, done
    );

    // Transmitter side
    modport slave (
        input  transmit, rnd_valid, rnd_data,
        output rnd_ack, tx, busy, done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_bit_timer
    import trng_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign o_bit_end = (r_cnt == LAST);

    // Free-running bit counter, restarted by the FSM on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/trng_uart_tx.sv
// Sends NUM_BYTES of a captured TRNG word as back-to-back UART 8N1 frames,
// low byte first, on each rising edge of the transmit button.
module trng_uart_tx
    import trng_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned NUM_BYTES    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    trng_uart_tx_if.slave bus
);

    localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_next;
    logic [1:0]  r_byte;
    logic [1:0]  w_byte_next;
    logic [31:0] r_word;
    logic [31:0] w_word_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        r_transmit_d;
    logic        w_trigger;
    logic        w_ack;
    logic        r_done;
    logic        w_done_next;
    logic        w_bit_end;
    logic        w_clear;

    assign w_trigger = bus.transmit && !r_transmit_d;
    assign w_clear   = (w_state_next != r_state);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .o_bit_end(w_bit_end)
    );

    // State, indices, captured word and registered line/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit        <= '0;
            r_byte       <= '0;
            r_word       <= '0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
            r_transmit_d <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_bit        <= w_bit_next;
            r_byte       <= w_byte_next;
            r_word       <= w_word_next;
            r_tx         <= w_tx_next;
            r_done       <= w_done_next;
            r_transmit_d <= bus.transmit;
        end
    end

    // Next-state logic; tx is computed from the next state so the line
    // stays aligned with the FSM despite being registered
    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        w_word_next  = r_word;
        w_ack        = 1'b0;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    if (bus.rnd_valid) begin
                        w_ack        = 1'b1;
                        w_word_next  = bus.rnd_data;
                        w_byte_next  = '0;
                        w_bit_next   = '0;
                        w_state_next = START;
                    end else begin
                        w_state_next = WAIT_RND;
                    end
                end
            end
            WAIT_RND: begin
                if (bus.rnd_valid) begin
                    w_ack        = 1'b1;
                    w_word_next  = bus.rnd_data;
                    w_byte_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_bit_next = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_byte == LAST_BYTE) begin
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_byte_next  = r_byte + 2'd1;
                        w_state_next = START;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_state_next == START) begin
            w_tx_next = 1'b0;
        end else if (w_state_next == DATA) begin
            w_tx_next = w_word_next[{w_byte_next, w_bit_next}];
        end else begin
            w_tx_next = 1'b1;
        end
    end

    assign bus.rnd_ack = w_ack;
    assign bus.tx      = r_tx;
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;

endmodule

// File: tb/tb_trng_uart_tx.sv
// Directed bench for trng_uart_tx with 4 clocks per bit and 2 bytes per trigger.
module tb_trng_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned NB    = 2;
    localparam int unsigned FRAME = 10 * CPB * NB;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    trng_uart_tx_if u_if ();

    trng_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (NB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected line level k cycles after capture, for the 2-byte frame sequence
    function automatic logic exp_tx(input logic [31:0] w, input int unsigned k);
        int unsigned byte_i;
        int unsigned slot;
        byte_i = k / (10 * CPB);
        slot   = (k % (10 * CPB)) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return w[byte_i * 8 + slot - 1];
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, " tx"},   32'(u_if.tx),      32'd1);
        check_eq({tag, " busy"}, 32'(u_if.busy),    32'd0);
        check_eq({tag, " done"}, 32'(u_if.done),    32'd0);
        check_eq({tag, " ack"},  32'(u_if.rnd_ack), 32'd0);
    endtask

    // Called at the negedge one cycle after capture; checks the whole frame and
    // the done pulse. retrig_at > 0 re-presses transmit mid-frame.
    task automatic run_frame(input string tag, input logic [31:0] w, input int retrig_at);
        for (int unsigned k = 0; k < FRAME; k++) begin
            check_eq($sformatf("%s tx c%0d", tag, k), 32'(u_if.tx), 32'(exp_tx(w, k)));
            check_eq($sformatf("%s busy c%0d", tag, k), 32'(u_if.busy), 32'd1);
            check_eq($sformatf("%s done c%0d", tag, k), 32'(u_if.done), 32'd0);
            if (retrig_at > 0 && k == 32'(retrig_at)) u_if.transmit = 1'b0;
            if (retrig_at > 0 && k == 32'(retrig_at + 2)) u_if.transmit = 1'b1;
            #1;
            check_eq($sformatf("%s ack c%0d", tag, k), 32'(u_if.rnd_ack), 32'd0);
            @(negedge clk);
        end
        check_eq({tag, " end done"}, 32'(u_if.done), 32'd1);
        check_eq({tag, " end busy"}, 32'(u_if.busy), 32'd0);
        check_eq({tag, " end tx"},   32'(u_if.tx),   32'd1);
        @(negedge clk);
        check_eq({tag, " done drop"}, 32'(u_if.done), 32'd0);
    endtask

    // Press transmit (from low) with rnd_valid already high; expects an ack pulse
    task automatic press_and_capture(input string tag);
        u_if.transmit = 1'b0;
        @(negedge clk);
        u_if.transmit = 1'b1;
        #1;
        check_eq({tag, " ack"}, 32'(u_if.rnd_ack), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        rst_n          = 1'b0;
        u_if.transmit  = 1'b0;
        u_if.rnd_valid = 1'b0;
        u_if.rnd_data  = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post reset");

        // Immediate capture, two bytes 0x5A then 0xA5
        u_if.rnd_valid = 1'b1;
        u_if.rnd_data  = 32'h0000_A55A;
        press_and_capture("basic");
        run_frame("basic", 32'h0000_A55A, 0);

        // No entropy at trigger: wait 20 cycles idle-high but busy
        u_if.rnd_valid = 1'b0;
        u_if.rnd_data  = 32'hFFFF_3C96;
        u_if.transmit  = 1'b0;
        @(negedge clk);
        u_if.transmit = 1'b1;
        #1;
        check_eq("wait trig ack", 32'(u_if.rnd_ack), 32'd0);
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk);
            check_eq($sformatf("wait busy c%0d", k), 32'(u_if.busy), 32'd1);
            check_eq($sformatf("wait tx c%0d", k),   32'(u_if.tx),   32'd1);
            check_eq($sformatf("wait ack c%0d", k),  32'(u_if.rnd_ack), 32'd0);
        end
        u_if.rnd_valid = 1'b1;
        #1;
        check_eq("wait capture ack", 32'(u_if.rnd_ack), 32'd1);
        @(negedge clk);
        u_if.rnd_valid = 1'b0;
        run_frame("waited", 32'hFFFF_3C96, 0);

        // Second press mid-frame is ignored; button left held afterwards
        u_if.rnd_valid = 1'b1;
        u_if.rnd_data  = 32'h0000_0F81;
        press_and_capture("retrig");
        run_frame("retrig", 32'h0000_0F81, 25);
        for (int unsigned k = 0; k < 50; k++) begin
            @(negedge clk);
            check_idle($sformatf("after retrig c%0d", k));
        end

        // Button held through reset release must not start a frame
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("held in reset");
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk);
            check_idle($sformatf("held after reset c%0d", k));
        end
        u_if.rnd_data = 32'h0000_3C0F;
        press_and_capture("after held");
        run_frame("after held", 32'h0000_3C0F, 0);

        // Reset at cycle 30 of a frame (line low at that point) aborts at once
        u_if.rnd_data = 32'h0000_0000;
        press_and_capture("abort");
        for (int unsigned k = 0; k < 30; k++) begin
            check_eq($sformatf("abort tx c%0d", k), 32'(u_if.tx), 32'(exp_tx(32'h0, k)));
            @(negedge clk);
        end
        check_eq("abort pre tx",   32'(u_if.tx),   32'd0);
        check_eq("abort pre busy", 32'(u_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort tx",   32'(u_if.tx),   32'd1);
        check_eq("abort busy", 32'(u_if.busy), 32'd0);
        check_eq("abort done", 32'(u_if.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        u_if.transmit = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge clk);
            check_idle($sformatf("after abort c%0d", k));
        end
        u_if.rnd_data = 32'h0000_6E19;
        press_and_capture("fresh");
        run_frame("fresh", 32'h0000_6E19, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
